// File: rtl/slave_port_arbiter_pkg.sv
// Shared interconnect definitions: command codes, arbiter FSM states and
// the per-master request-tracker states the arbiter's pulses advance.
package slave_port_arbiter_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        TRK_NO_REQ = 2'd0,
        TRK_WAIT   = 2'd1,
        TRK_W_ACK  = 2'd2,
        TRK_W_DATA = 2'd3
    } trk_state_e;

endpackage

// File: rtl/slave_port_arbiter_if.sv
// Bundle of master-side and slave-side signals around one slave port.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface slave_port_arbiter_if #(
    parameter int N_M = 2,
    parameter int AW  = 8,
    parameter int DW  = 8,
    parameter int IDW = 1
);
    logic [N_M-1:0]    m_req;
    logic [N_M-1:0]    m_cmd;
    logic [N_M*AW-1:0] m_addr;
    logic [N_M*DW-1:0] m_wdata;
    logic [N_M-1:0]    req_sent;
    logic [N_M-1:0]    ack_out;
    logic [N_M-1:0]    data_read;
    logic [DW-1:0]     m_rdata;
    logic              s_req;
    logic              s_cmd;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic              s_ack;
    logic              s_resp;
    logic [DW-1:0]     s_rdata;
    logic [IDW-1:0]    grant_id;

    modport slave (
        input  m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
        output req_sent, ack_out, data_read, m_rdata,
        output s_req, s_cmd, s_addr, s_wdata, grant_id
    );

    modport master (
        output m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
        input  req_sent, ack_out, data_read, m_rdata,
        input  s_req, s_cmd, s_addr, s_wdata, grant_id
    );
endinterface

// File: rtl/slave_port_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the search
// starts after 'last', priority-encode the lowest set bit, then unrotate.
module slave_port_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          valid
);
    int           start;
    int           k;
    logic [N-1:0] rot;

    always_comb begin
        start = (int'(last) + 1) % N;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[(start + i) % N];
        end
        k = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = i;
            end
        end
        grant = IW'((start + k) % N);
        valid = |req;
    end
endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave arbiter: grants one waiting master per transaction in round-robin
// order, forwards its latched command to the slave and returns ack/read data.
module slave_port_arbiter
    import slave_port_arbiter_pkg::*;
#(
    parameter int N_M = 2,
    parameter int AW  = 8,
    parameter int DW  = 8,
    parameter int IDW = 1
) (
    input  logic                clk,
    input  logic                reset,
    slave_port_arbiter_if.slave bus
);
    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic           s_req_q, s_req_d;
    logic           s_cmd_q, s_cmd_d;
    logic [AW-1:0]  s_addr_q, s_addr_d;
    logic [DW-1:0]  s_wdata_q, s_wdata_d;
    logic [DW-1:0]  m_rdata_q, m_rdata_d;
    logic [N_M-1:0] req_sent_q, req_sent_d;
    logic [N_M-1:0] ack_q, ack_d;
    logic [N_M-1:0] data_read_q, data_read_d;

    logic           pick_vld;
    logic [IDW-1:0] pick_id;
    int             pick_i;
    int             grant_i;

    slave_port_arbiter_rr_pick #(.N(N_M), .IW(IDW)) u_pick (
        .req   (bus.m_req),
        .last  (last_q),
        .grant (pick_id),
        .valid (pick_vld)
    );

    assign pick_i  = int'(pick_id);
    assign grant_i = int'(grant_q);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        s_req_d     = s_req_q;
        s_cmd_d     = s_cmd_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        m_rdata_d   = m_rdata_q;
        req_sent_d  = '0;
        ack_d       = '0;
        data_read_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d            = pick_id;
                    s_cmd_d            = bus.m_cmd[pick_i];
                    s_addr_d           = bus.m_addr[pick_i*AW +: AW];
                    s_wdata_d          = bus.m_wdata[pick_i*DW +: DW];
                    s_req_d            = 1'b1;
                    req_sent_d[pick_i] = 1'b1;
                    state_d            = ST_REQ;
                end
            end
            ST_REQ: begin
                // The pointer only advances once the slave has taken the request.
                if (bus.s_ack) begin
                    s_req_d        = 1'b0;
                    ack_d[grant_i] = 1'b1;
                    last_d         = grant_q;
                    state_d        = (s_cmd_q == CMD_READ) ? ST_RESP : ST_IDLE;
                end
            end
            ST_RESP: begin
                if (bus.s_resp) begin
                    m_rdata_d            = bus.s_rdata;
                    data_read_d[grant_i] = 1'b1;
                    state_d              = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= IDW'(N_M - 1);
            s_req_q     <= 1'b0;
            s_cmd_q     <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            m_rdata_q   <= '0;
            req_sent_q  <= '0;
            ack_q       <= '0;
            data_read_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            s_req_q     <= s_req_d;
            s_cmd_q     <= s_cmd_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            m_rdata_q   <= m_rdata_d;
            req_sent_q  <= req_sent_d;
            ack_q       <= ack_d;
            data_read_q <= data_read_d;
        end
    end

    assign bus.req_sent  = req_sent_q;
    assign bus.ack_out   = ack_q;
    assign bus.data_read = data_read_q;
    assign bus.m_rdata   = m_rdata_q;
    assign bus.s_req     = s_req_q;
    assign bus.s_cmd     = s_cmd_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.grant_id  = grant_q;
endmodule
